// File: rtl/sram_out_reader.sv
// Drains a programmed run of words from the 16-entry output SRAM into a valid/ready stream.
// Optional `SRAM_OUT_READER_LAST_EN` adds out_last, which marks the final word of a run.
module sram_out_reader #(
  parameter int sram_bit   = 160,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [3:0]          base_addr,
  input  logic [4:0]          num_words,
  output logic                busy,
  output logic                done,
  output logic                sram_cen,
  output logic                sram_wen,
  output logic [3:0]          sram_a,
  input  logic [sram_bit-1:0] sram_q,
  output logic [sram_bit-1:0] out_data,
  output logic                out_valid,
`ifdef SRAM_OUT_READER_LAST_EN
  output logic                out_last,
`endif
  input  logic                out_ready
);

  localparam int PW = $clog2(FIFO_DEPTH);

  // Stream handshake: a word moves on any rising edge where out_valid & out_ready;
  // while out_valid=1 and out_ready=0, out_valid and out_data hold their values.
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;

  state_t              state_q, state_d;
  logic                cen_q, cen_d;
  logic [3:0]          a_q, a_d;
  logic [3:0]          base_q, base_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [4:0]          issued_q, issued_d;
  logic [4:0]          acc_q, acc_d;
  logic                cap_q;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PW:0]         occ_q, occ_d;
  logic [sram_bit-1:0] mem_q [FIFO_DEPTH];

  logic                pop;
  logic                push;
  logic [4:0]          clamp;
  logic [PW:0]         occ_after_pop;
  logic [PW:0]         outstanding;
  logic                credit_ok;

  assign out_valid     = (occ_q != '0);
  assign pop           = out_valid & out_ready;
  assign push          = cap_q;
  assign clamp         = (num_words > 5'd16) ? 5'd16 : num_words;
  assign occ_after_pop = occ_q - {{PW{1'b0}}, pop};
  // Reads in flight: one presented to the SRAM now, one whose data lands this edge.
  assign outstanding   = {{PW{1'b0}}, ~cen_q} + {{PW{1'b0}}, cap_q};
  assign credit_ok     = ({1'b0, occ_after_pop} + {1'b0, outstanding} + 1'b1) <= (PW + 2)'(FIFO_DEPTH);

  assign busy     = (state_q == ISSUE) || (state_q == DRAIN);
  assign done     = (state_q == FINISH);
  assign sram_cen = cen_q;
  assign sram_wen = 1'b1;
  assign sram_a   = a_q;
  assign out_data = out_valid ? mem_q[rd_ptr_q] : '0;
`ifdef SRAM_OUT_READER_LAST_EN
  assign out_last = out_valid && busy && ((acc_q + 5'd1) == cnt_q);
`endif

  always_comb begin
    state_d  = state_q;
    cen_d    = 1'b1;
    a_d      = a_q;
    base_d   = base_q;
    cnt_d    = cnt_q;
    issued_d = issued_q;
    acc_d    = acc_q + {4'd0, pop};
    case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (start) begin
          base_d   = base_addr;
          cnt_d    = clamp;
          issued_d = 5'd0;
          acc_d    = 5'd0;
          if (clamp == 5'd0) begin
            state_d = FINISH;
          end else begin
            // The FIFO is empty here, so the first read needs no credit check.
            cen_d    = 1'b0;
            a_d      = base_addr;
            issued_d = 5'd1;
            state_d  = (clamp == 5'd1) ? DRAIN : ISSUE;
          end
        end
      end
      ISSUE: begin
        if (credit_ok) begin
          cen_d    = 1'b0;
          a_d      = base_q + issued_q[3:0];
          issued_d = issued_q + 5'd1;
          if ((issued_q + 5'd1) == cnt_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if ((acc_q + {4'd0, pop}) == cnt_q) state_d = FINISH;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{(PW-1){1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{(PW-1){1'b0}}, pop};
    occ_d    = occ_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      cen_q    <= 1'b1;
      a_q      <= 4'd0;
      base_q   <= 4'd0;
      cnt_q    <= 5'd0;
      issued_q <= 5'd0;
      acc_q    <= 5'd0;
      cap_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      state_q  <= state_d;
      cen_q    <= cen_d;
      a_q      <= a_d;
      base_q   <= base_d;
      cnt_q    <= cnt_d;
      issued_q <= issued_d;
      acc_q    <= acc_d;
      cap_q    <= ~cen_q;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: out_data is masked whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= sram_q;
  end

endmodule

// File: tb/tb_sram_out_reader.sv
// Directed bench for sram_out_reader: SRAM model, per-run expected queues, negedge monitor.
module tb_sram_out_reader;
  localparam int W = 160;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   base_addr = 4'd0;
  logic [4:0]   num_words = 5'd0;
  logic         busy, done, sram_cen, sram_wen, out_valid;
  logic         out_ready = 1'b1;
  logic [3:0]   sram_a;
  logic [W-1:0] sram_q = '0;
  logic [W-1:0] out_data;
`ifdef SRAM_OUT_READER_LAST_EN
  logic         out_last;
`endif

  sram_out_reader #(.sram_bit(W), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .base_addr(base_addr),
    .num_words(num_words), .busy(busy), .done(done), .sram_cen(sram_cen),
    .sram_wen(sram_wen), .sram_a(sram_a), .sram_q(sram_q), .out_data(out_data),
    .out_valid(out_valid),
`ifdef SRAM_OUT_READER_LAST_EN
    .out_last(out_last),
`endif
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem [16];
  always @(posedge clk) if (!sram_cen) sram_q <= mem[sram_a];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_last_q[$];
  logic [3:0]   addr_q[$];
  int rd_cnt = 0;
  int acc_cnt = 0;
  int first_valid_cyc = -1;
  int last_xfer_cyc = -1;
  logic ready_rand = 1'b0;
  logic prev_stall = 1'b0;
  logic [W-1:0] prev_data = '0;

  function automatic logic [W-1:0] word(input int k);
    logic [7:0] b;
    b = 8'(k * 17);
    return {20{b}};
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_rand ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  always @(negedge clk) begin
    if (reset_n) begin
      if (!sram_cen) begin
        rd_cnt++;
        check("sram_wen_high", sram_wen, 1'b1);
        check("read_expected", addr_q.size() != 0, 1'b1);
        if (addr_q.size() != 0) check("sram_a", sram_a, addr_q.pop_front());
        check("reads_ahead_le4", (rd_cnt - acc_cnt) <= 4, 1'b1);
      end
      if (prev_stall) begin
        check("stall_valid_held", out_valid, 1'b1);
        check("stall_data_held", out_data, prev_data);
      end
      if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (out_valid && out_ready) begin
        check("word_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) begin
          check("out_data", out_data, exp_q.pop_front());
`ifdef SRAM_OUT_READER_LAST_EN
          check("out_last", out_last, exp_last_q.pop_front());
`else
          void'(exp_last_q.pop_front());
`endif
        end
        acc_cnt++;
        last_xfer_cyc = cyc;
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_done"}, done, 1'b0);
    check({tag, "_cen"}, sram_cen, 1'b1);
    check({tag, "_wen"}, sram_wen, 1'b1);
    check({tag, "_a"}, sram_a, 4'd0);
    check({tag, "_valid"}, out_valid, 1'b0);
    check({tag, "_data"}, out_data, '0);
`ifdef SRAM_OUT_READER_LAST_EN
    check({tag, "_last"}, out_last, 1'b0);
`endif
  endtask

  // Called just after a rising edge; returns just after a rising edge.
  task automatic run(input logic [3:0] b, input logic [4:0] n, input bit chk_lat,
                     input bit mid_start, input int abort_after);
    int k, rd0, acc0, c0, done_cyc;
    k = (n > 5'd16) ? 16 : int'(n);
    for (int i = 0; i < k; i++) begin
      exp_q.push_back(word((int'(b) + i) % 16));
      exp_last_q.push_back(i == k - 1);
      addr_q.push_back(4'((int'(b) + i) % 16));
    end
    rd0 = rd_cnt;
    acc0 = acc_cnt;
    done_cyc = -1;
    first_valid_cyc = -1;
    start = 1'b1;
    base_addr = b;
    num_words = n;
    @(posedge clk);
    #1;
    start = 1'b0;
    c0 = cyc;
    if (k > 0) check("busy_after_start", busy, 1'b1);
    for (int t = 0; t < 300; t++) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (abort_after > 0 && (acc_cnt - acc0) >= abort_after) begin
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        exp_last_q.delete();
        addr_q.delete();
        acc_cnt = rd_cnt;
        prev_stall = 1'b0;
        repeat (2) begin
          @(posedge clk);
          #1;
          check("abort_no_done", done, 1'b0);
          check("abort_cen_idle", sram_cen, 1'b1);
        end
        reset_n = 1'b1;
        return;
      end
      start = (mid_start && t == 4);
      if (start) begin
        base_addr = 4'd9;
        num_words = 5'd3;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    check("done_seen", done_cyc >= 0, 1'b1);
    if (done_cyc >= 0) begin
      if (k == 0) check("done_latency_empty", done_cyc, c0);
      else check("done_after_last_xfer", done_cyc, last_xfer_cyc + 1);
    end
    check("reads_issued", rd_cnt - rd0, k);
    check("words_left", exp_q.size(), 0);
    check("addrs_left", addr_q.size(), 0);
    if (k == 0) check("no_valid_on_empty", first_valid_cyc, -1);
    else if (chk_lat) check("first_valid_latency", first_valid_cyc, c0 + 2);
    @(posedge clk);
    #1;
    check("done_one_cycle", done, 1'b0);
    check("busy_after_done", busy, 1'b0);
  endtask

  initial begin
    for (int k = 0; k < 16; k++) mem[k] = word(k);
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    run(4'd0, 5'd16, 1'b1, 1'b0, 0);
    run(4'd14, 5'd4, 1'b1, 1'b0, 0);
    run(4'd0, 5'd0, 1'b0, 1'b0, 0);
    ready_rand = 1'b1;
    run(4'd0, 5'd8, 1'b0, 1'b0, 0);
    ready_rand = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    run(4'd3, 5'd20, 1'b0, 1'b1, 0);
    run(4'd0, 5'd10, 1'b0, 1'b0, 3);
    @(posedge clk);
    #1;
    run(4'd0, 5'd10, 1'b1, 1'b0, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/sram_out_reader.md
Name: sram_out_reader

Overview:
- Read-side initiator for the 16-entry output SRAM.
- Drives the SRAM control interface (CEN/WEN/A active-low controls, 1-cycle registered read data) to drain a programmed run of words.
- Presents each word to the downstream consumer over a valid/ready stream; a small skid FIFO absorbs the SRAM read latency and downstream backpressure.
- Sits between the output SRAM and the host/next-core readout path.

Parameters:
- sram_bit, 160, SRAM word width in bits.
- FIFO_DEPTH, 4, skid buffer depth in words; fixed at 4, power of 2.

Ports:
- clk  input  1  clock, rising edge.
- reset_n  input  1  asynchronous active-low reset.
- start  input  1  1-cycle pulse; begin a drain run.
- base_addr  input  4  first SRAM address of the run.
- num_words  input  5  words to read; 0..16, values >16 clamp to 16.
- busy  output  1  run in progress.
- done  output  1  1-cycle pulse when the run completes.
- sram_cen  output  1  SRAM chip enable, active low, registered.
- sram_wen  output  1  SRAM write enable; tied 1 (read-only initiator).
- sram_a  output  4  SRAM address, registered.
- sram_q  input  sram_bit  SRAM read data, valid the cycle after the edge that sampled sram_cen=0.
- out_data  output  sram_bit  stream data, FIFO head.
- out_valid  output  1  stream valid.
- out_ready  input  1  stream ready; a transfer occurs on an edge with out_valid & out_ready.

Behaviour:
- Reset (async, reset_n=0):
  - Outputs: busy=0, done=0, sram_cen=1, sram_wen=1, sram_a=0, out_valid=0, out_data=0.
  - Internal: FIFO emptied; issue/accept counters cleared; state IDLE.
  - Reset mid-run aborts the run; no further SRAM accesses; no done pulse.
- State IDLE:
  - start=1 latches base_addr and min(num_words,16).
  - If the count is 0: go to FINISH; no SRAM access.
  - Otherwise: go to ISSUE; busy=1 from the next cycle.
  - start while busy is ignored.
- State ISSUE:
  - Each cycle, sram_cen=0 with sram_a = base + issued (mod 16, wraps 15 -> 0), provided occ + outstanding + 1 <= FIFO_DEPTH.
  - occ = FIFO occupancy after this cycle's pop.
  - outstanding = reads issued whose data is not yet captured (at most 2).
  - Otherwise sram_cen=1.
  - After the last read is issued, sram_cen=1 and go to DRAIN.
- Data capture: sram_q is pushed into the FIFO on the edge two cycles after the issue cycle (one cycle for the registered CEN/A, one for the SRAM read). Pushes never overflow, by construction of the credit rule.
- State DRAIN: wait until every word has been captured and accepted downstream, then go to FINISH.
- State FINISH: done=1 for exactly one cycle, busy=0, return to IDLE. A start in the done cycle is accepted.
- Latency with out_ready held 1:
  - Start sampled at edge E0; first sram_cen=0 after E0; first out_valid after E2.
  - Thereafter one word per cycle, no bubbles.
  - done rises the cycle after the last transfer.
- Stream rules:
  - out_data/out_valid are stable while out_valid=1 and out_ready=0.
  - Words are delivered in address order, no loss or duplication.
- Simultaneous push and pop on a full FIFO is legal and keeps occupancy unchanged.
- sram_wen is never 0 and the reader never writes the SRAM.

Optional Feature:
- Macro: SRAM_OUT_READER_LAST_EN.
- Defined: adds output out_last (1 bit, reset 0), which is 1 alongside out_valid on the final word of the run only.
- Undefined: port absent; all other behaviour identical.

Test Plan:
- Preload mem[k]=k*0x11, base=0, num=16, out_ready=1 -> 16 words 0x00..0xFF consecutively; first out_valid 2 cycles after start edge; done 1 cycle after last transfer; out_last on word 16 when enabled.
- base=14, num=4 -> sram_a sequence 14,15,0,1; data mem14,mem15,mem0,mem1.
- num=0 -> done pulse one cycle after start; sram_cen stays 1; out_valid stays 0.
- base=0, num=8, out_ready random 30% duty -> FIFO never exceeds 4, data held stable while stalled, all 8 words in order, no more than 4 reads ahead of acceptance.
- num=20 -> clamped to 16 transfers; start pulsed mid-run -> ignored, no extra reads.
- reset_n low after 3 transfers of a 10-word run -> outputs at reset values asynchronously; no done; a new run after release reads correct data from base.
